// File: rtl/adder_tree_pkg.sv
// Shared types and widths for the two-requester adder-tree arbiter.
// Holds the FSM state encoding, operand/sum widths and the grant selection helper.
package adder_tree_pkg;

  localparam int NARROW_W = 4;
  localparam int WIDE_W   = 8;
  localparam int SUM1_W   = 5;
  localparam int SUM2_W   = 9;
  localparam int SUM3_W   = 10;
  localparam int CNT_W    = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    HOLD = 2'b10
  } state_e;

  typedef struct packed {
    logic [NARROW_W-1:0] a;
    logic [NARROW_W-1:0] b;
    logic [WIDE_W-1:0]   c;
    logic [WIDE_W-1:0]   d;
  } operands_t;

  // A lone requester always wins; on contention the priority pointer decides.
  function automatic logic pick_grant(input logic v0, input logic v1, input logic ptr);
    logic g;
    if (v0 && v1) begin
      g = ptr;
    end else if (v1) begin
      g = 1'b1;
    end else begin
      g = 1'b0;
    end
    return g;
  endfunction

endpackage

// File: rtl/adder_tree_procedural.sv
// Combinational two-level adder tree: sum1=a+b, sum2=c+d, sum3=sum1+sum2.
// All additions are unsigned and zero-extended, so no result can overflow its width.
module adder_tree_procedural
  import adder_tree_pkg::*;
(
  input  logic [NARROW_W-1:0] a_i,
  input  logic [NARROW_W-1:0] b_i,
  input  logic [WIDE_W-1:0]   c_i,
  input  logic [WIDE_W-1:0]   d_i,
  output logic [SUM1_W-1:0]   sum1_o,
  output logic [SUM2_W-1:0]   sum2_o,
  output logic [SUM3_W-1:0]   sum3_o
);

  logic [SUM1_W-1:0] sum1_s;
  logic [SUM2_W-1:0] sum2_s;
  logic [SUM3_W-1:0] sum3_s;

  // Leaf adders feed the root adder.
  always_comb begin
    sum1_s = {1'b0, a_i} + {1'b0, b_i};
    sum2_s = {1'b0, c_i} + {1'b0, d_i};
    sum3_s = {{(SUM3_W-SUM1_W){1'b0}}, sum1_s} + {{(SUM3_W-SUM2_W){1'b0}}, sum2_s};
  end

  assign sum1_o = sum1_s;
  assign sum2_o = sum2_s;
  assign sum3_o = sum3_s;

endmodule

// File: rtl/adder_tree_arbiter.sv
// Round-robin arbiter between two operand requesters feeding one adder tree.
// One operand set is accepted in IDLE, summed in CALC and held in HOLD until consumed.
module adder_tree_arbiter
  import adder_tree_pkg::*;
#(
  parameter bit PRIO_RESET = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [NARROW_W-1:0] req0_a,
  input  logic [NARROW_W-1:0] req0_b,
  input  logic [WIDE_W-1:0]   req0_c,
  input  logic [WIDE_W-1:0]   req0_d,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [NARROW_W-1:0] req1_a,
  input  logic [NARROW_W-1:0] req1_b,
  input  logic [WIDE_W-1:0]   req1_c,
  input  logic [WIDE_W-1:0]   req1_d,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [SUM1_W-1:0]   res_sum1,
  output logic [SUM2_W-1:0]   res_sum2,
  output logic [SUM3_W-1:0]   res_sum3,
  output logic                res_id,
  output logic [CNT_W-1:0]    done_cnt
);

  state_e            state_q;
  logic              ptr_q;
  operands_t         op_q;
  logic              id_q;
  logic              res_valid_q;
  logic [SUM1_W-1:0] res_sum1_q;
  logic [SUM2_W-1:0] res_sum2_q;
  logic [SUM3_W-1:0] res_sum3_q;
  logic              res_id_q;
  logic [CNT_W-1:0]  done_cnt_q;

  logic              grant_s;
  logic              accept_s;
  logic              req0_ready_s;
  logic              req1_ready_s;
  operands_t         op_d;
  logic [CNT_W-1:0]  done_cnt_d;
  logic [SUM1_W-1:0] tree_sum1_s;
  logic [SUM2_W-1:0] tree_sum2_s;
  logic [SUM3_W-1:0] tree_sum3_s;

  // Grant decision and ready generation; ready is held low while reset is asserted.
  always_comb begin
    grant_s      = pick_grant(req0_valid, req1_valid, ptr_q);
    accept_s     = rst_n && (state_q == IDLE) && (req0_valid || req1_valid);
    req0_ready_s = accept_s && (grant_s == 1'b0);
    req1_ready_s = accept_s && (grant_s == 1'b1);
    done_cnt_d   = done_cnt_q + 8'd1;
    if (grant_s) begin
      op_d = '{a: req1_a, b: req1_b, c: req1_c, d: req1_d};
    end else begin
      op_d = '{a: req0_a, b: req0_b, c: req0_c, d: req0_d};
    end
  end

  adder_tree_procedural u_tree (
    .a_i    (op_q.a),
    .b_i    (op_q.b),
    .c_i    (op_q.c),
    .d_i    (op_q.d),
    .sum1_o (tree_sum1_s),
    .sum2_o (tree_sum2_s),
    .sum3_o (tree_sum3_s)
  );

  // Main FSM: accept -> compute -> hold until the consumer takes the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= PRIO_RESET;
      op_q        <= '0;
      id_q        <= 1'b0;
      res_valid_q <= 1'b0;
      res_sum1_q  <= '0;
      res_sum2_q  <= '0;
      res_sum3_q  <= '0;
      res_id_q    <= 1'b0;
      done_cnt_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_s) begin
            op_q    <= op_d;
            id_q    <= grant_s;
            ptr_q   <= ~grant_s;
            state_q <= CALC;
          end else begin
            state_q <= IDLE;
          end
        end
        CALC: begin
          res_sum1_q  <= tree_sum1_s;
          res_sum2_q  <= tree_sum2_s;
          res_sum3_q  <= tree_sum3_s;
          res_id_q    <= id_q;
          res_valid_q <= 1'b1;
          state_q     <= HOLD;
        end
        HOLD: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            done_cnt_q  <= done_cnt_d;
            state_q     <= IDLE;
          end else begin
            state_q <= HOLD;
          end
        end
        default: begin
          res_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign req0_ready = req0_ready_s;
  assign req1_ready = req1_ready_s;
  assign res_valid  = res_valid_q;
  assign res_sum1   = res_sum1_q;
  assign res_sum2   = res_sum2_q;
  assign res_sum3   = res_sum3_q;
  assign res_id     = res_id_q;
  assign done_cnt   = done_cnt_q;

endmodule

// File: tb/tb_adder_tree_arbiter.sv
// Directed self-checking bench for adder_tree_arbiter with hand-computed expectations.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_adder_tree_arbiter;

  logic       clk;
  logic       rst_n;
  logic       req0_valid, req1_valid;
  logic       req0_ready, req1_ready;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic [7:0] req0_c, req0_d, req1_c, req1_d;
  logic       res_valid, res_ready;
  logic [4:0] res_sum1;
  logic [8:0] res_sum2;
  logic [9:0] res_sum3;
  logic       res_id;
  logic [7:0] done_cnt;

  int n_vec;
  int n_err;
  int exp_done;

  adder_tree_arbiter #(.PRIO_RESET(1'b0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_c     (req0_c),
    .req0_d     (req0_d),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_c     (req1_c),
    .req1_d     (req1_d),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_sum1   (res_sum1),
    .res_sum2   (res_sum2),
    .res_sum3   (res_sum3),
    .res_id     (res_id),
    .done_cnt   (done_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req0(input logic [3:0] a, input logic [3:0] b, input logic [7:0] c, input logic [7:0] d);
    req0_a = a; req0_b = b; req0_c = c; req0_d = d;
  endtask

  task automatic set_req1(input logic [3:0] a, input logic [3:0] b, input logic [7:0] c, input logic [7:0] d);
    req1_a = a; req1_b = b; req1_c = c; req1_d = d;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    n_vec++;
    if ({res_valid, res_id, res_sum1, res_sum2, res_sum3, done_cnt, req0_ready, req1_ready} !== 35'd0) begin
      n_err++;
      $display("FAIL reset_state: got %h expected 0", {res_valid, res_id, res_sum1, res_sum2, res_sum3, done_cnt, req0_ready, req1_ready});
    end
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst_n = 1'b1;
    exp_done = 0;
    @(negedge clk);
    n_vec++;
    if ({req0_ready, req1_ready, res_valid} !== 3'b000) begin
      n_err++;
      $display("FAIL idle_after_reset: got %b expected 000", {req0_ready, req1_ready, res_valid});
    end
    tick();
  endtask

  task automatic test_dual();
    set_req0(4'd1, 4'd2, 8'd79, 8'd141);
    set_req1(4'd7, 4'd14, 8'd47, 8'd175);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      n_err++;
      $display("FAIL dual_grant0: got %b expected 10", {req0_ready, req1_ready});
    end
    tick();
    @(negedge clk);
    n_vec++;
    if ({req0_ready, req1_ready, res_valid} !== 3'b000) begin
      n_err++;
      $display("FAIL dual_calc: got %b expected 000", {req0_ready, req1_ready, res_valid});
    end
    tick();
    @(negedge clk);
    n_vec++;
    if ({res_valid, res_id, res_sum1, res_sum2, res_sum3} !== {1'b1, 1'b0, 5'd3, 9'd220, 10'd223}) begin
      n_err++;
      $display("FAIL dual_res0: got v=%b id=%b s1=%0d s2=%0d s3=%0d expected v=1 id=0 s1=3 s2=220 s3=223",
               res_valid, res_id, res_sum1, res_sum2, res_sum3);
    end
    res_ready = 1'b1;
    tick();
    exp_done++;
    @(negedge clk);
    n_vec++;
    if ({req0_ready, req1_ready, res_valid, done_cnt} !== {3'b010, 8'(exp_done)}) begin
      n_err++;
      $display("FAIL dual_grant1: got rdy=%b%b v=%b cnt=%0d expected rdy=01 v=0 cnt=%0d",
               req0_ready, req1_ready, res_valid, done_cnt, exp_done);
    end
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    set_req1(4'd0, 4'd0, 8'd0, 8'd0);
    tick();
    @(negedge clk);
    n_vec++;
    if ({res_valid, res_id, res_sum1, res_sum2, res_sum3} !== {1'b1, 1'b1, 5'd21, 9'd222, 10'd243}) begin
      n_err++;
      $display("FAIL dual_res1: got v=%b id=%b s1=%0d s2=%0d s3=%0d expected v=1 id=1 s1=21 s2=222 s3=243",
               res_valid, res_id, res_sum1, res_sum2, res_sum3);
    end
    tick();
    res_ready = 1'b0;
    exp_done++;
  endtask

  task automatic test_single();
    res_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      n_vec++;
      if ({res_valid, done_cnt} !== {1'b0, 8'(exp_done)}) begin
        n_err++;
        $display("FAIL idle_res_ready: got v=%b cnt=%0d expected v=0 cnt=%0d", res_valid, done_cnt, exp_done);
      end
      tick();
    end
    res_ready = 1'b0;
    set_req0(4'd3, 4'd10, 8'd47, 8'd45);
    req0_valid = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      n_err++;
      $display("FAIL single_ready: got %b expected 10", {req0_ready, req1_ready});
    end
    tick();
    req0_valid = 1'b0;
    set_req0(4'd15, 4'd15, 8'd255, 8'd255);
    @(negedge clk);
    n_vec++;
    if ({req0_ready, req1_ready, res_valid} !== 3'b000) begin
      n_err++;
      $display("FAIL single_calc: got %b expected 000", {req0_ready, req1_ready, res_valid});
    end
    tick();
    @(negedge clk);
    n_vec++;
    if ({res_valid, res_id, res_sum1, res_sum2, res_sum3} !== {1'b1, 1'b0, 5'd13, 9'd92, 10'd105}) begin
      n_err++;
      $display("FAIL single_res: got v=%b id=%b s1=%0d s2=%0d s3=%0d expected v=1 id=0 s1=13 s2=92 s3=105",
               res_valid, res_id, res_sum1, res_sum2, res_sum3);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    exp_done++;
    @(negedge clk);
    n_vec++;
    if ({res_valid, done_cnt} !== {1'b0, 8'(exp_done)}) begin
      n_err++;
      $display("FAIL single_done: got v=%b cnt=%0d expected v=0 cnt=%0d", res_valid, done_cnt, exp_done);
    end
    tick();
  endtask

  // Pointer now names req1 because the previous lone req0 accept toggled it.
  task automatic test_max();
    set_req0(4'd6, 4'd11, 8'd143, 8'd237);
    set_req1(4'd15, 4'd15, 8'd255, 8'd255);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      n_err++;
      $display("FAIL max_grant: got %b expected 01", {req0_ready, req1_ready});
    end
    tick();
    req1_valid = 1'b0;
    tick();
    @(negedge clk);
    n_vec++;
    if ({res_valid, res_id, res_sum1, res_sum2, res_sum3, req0_ready, req1_ready} !==
        {1'b1, 1'b1, 5'd30, 9'd510, 10'd540, 2'b00}) begin
      n_err++;
      $display("FAIL max_res: got v=%b id=%b s1=%0d s2=%0d s3=%0d rdy=%b%b expected v=1 id=1 s1=30 s2=510 s3=540 rdy=00",
               res_valid, res_id, res_sum1, res_sum2, res_sum3, req0_ready, req1_ready);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    exp_done++;
  endtask

  task automatic test_stall();
    @(negedge clk);
    n_vec++;
    if ({req0_ready, req1_ready, done_cnt} !== {2'b10, 8'(exp_done)}) begin
      n_err++;
      $display("FAIL stall_waiting_grant: got rdy=%b%b cnt=%0d expected rdy=10 cnt=%0d",
               req0_ready, req1_ready, done_cnt, exp_done);
    end
    tick();
    req0_valid = 1'b0;
    tick();
    for (int k = 0; k < 5; k++) begin
      req1_valid = (k == 1 || k == 2) ? 1'b1 : 1'b0;
      @(negedge clk);
      n_vec++;
      if ({res_valid, res_id, res_sum1, res_sum2, res_sum3, req0_ready, req1_ready, done_cnt} !==
          {1'b1, 1'b0, 5'd17, 9'd380, 10'd397, 2'b00, 8'(exp_done)}) begin
        n_err++;
        $display("FAIL stall_hold[%0d]: got v=%b id=%b s1=%0d s2=%0d s3=%0d rdy=%b%b cnt=%0d expected v=1 id=0 s1=17 s2=380 s3=397 rdy=00 cnt=%0d",
                 k, res_valid, res_id, res_sum1, res_sum2, res_sum3, req0_ready, req1_ready, done_cnt, exp_done);
      end
      tick();
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    exp_done++;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_vec++;
      if ({req0_ready, req1_ready, res_valid, done_cnt} !== {3'b000, 8'(exp_done)}) begin
        n_err++;
        $display("FAIL stall_after[%0d]: got rdy=%b%b v=%b cnt=%0d expected rdy=00 v=0 cnt=%0d",
                 k, req0_ready, req1_ready, res_valid, done_cnt, exp_done);
      end
      tick();
    end
  endtask

  task automatic test_reset_hold();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_done = 0;
    set_req1(4'd1, 4'd1, 8'd1, 8'd1);
    req1_valid = 1'b1;
    tick();
    req1_valid = 1'b0;
    tick();
    @(negedge clk);
    n_vec++;
    if ({res_valid, res_id, res_sum3} !== {1'b1, 1'b1, 10'd4}) begin
      n_err++;
      $display("FAIL rst_hold_pre: got v=%b id=%b s3=%0d expected v=1 id=1 s3=4", res_valid, res_id, res_sum3);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({res_valid, res_id, res_sum1, res_sum2, res_sum3, done_cnt} !== 33'd0) begin
      n_err++;
      $display("FAIL rst_hold_async: got %h expected 0", {res_valid, res_id, res_sum1, res_sum2, res_sum3, done_cnt});
    end
    tick();
    rst_n = 1'b1;
    set_req0(4'd2, 4'd3, 8'd4, 8'd5);
    req0_valid = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({req0_ready, req1_ready, res_valid, done_cnt} !== 11'b100_00000000) begin
      n_err++;
      $display("FAIL rst_first_accept: got rdy=%b%b v=%b cnt=%0d expected rdy=10 v=0 cnt=0",
               req0_ready, req1_ready, res_valid, done_cnt);
    end
    tick();
    req0_valid = 1'b0;
    tick();
    @(negedge clk);
    n_vec++;
    if ({res_valid, res_id, res_sum1, res_sum2, res_sum3} !== {1'b1, 1'b0, 5'd5, 9'd9, 10'd14}) begin
      n_err++;
      $display("FAIL rst_first_res: got v=%b id=%b s1=%0d s2=%0d s3=%0d expected v=1 id=0 s1=5 s2=9 s3=14",
               res_valid, res_id, res_sum1, res_sum2, res_sum3);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    exp_done++;
  endtask

  task automatic test_wrap();
    logic [7:0] iv;
    logic       eid;
    int         e1, e2, e3;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_done = 0;
    res_ready = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int i = 0; i < 257; i++) begin
      iv = 8'(i);
      set_req0(iv[3:0], 4'd5, iv, 8'd200);
      set_req1(4'd9, iv[7:4], 8'd255, iv);
      eid = iv[0];
      @(negedge clk);
      n_vec++;
      if ({req0_ready, req1_ready, done_cnt} !== {~eid, eid, 8'(exp_done)}) begin
        n_err++;
        $display("FAIL wrap_grant[%0d]: got rdy=%b%b cnt=%0d expected rdy=%b%b cnt=%0d",
                 i, req0_ready, req1_ready, done_cnt, ~eid, eid, exp_done);
      end
      if (i == 256) break;
      if (eid) begin
        e1 = 9 + int'(iv[7:4]);
        e2 = 255 + int'(iv);
      end else begin
        e1 = int'(iv[3:0]) + 5;
        e2 = int'(iv) + 200;
      end
      e3 = e1 + e2;
      tick();
      tick();
      @(negedge clk);
      n_vec++;
      if ({res_valid, res_id, res_sum1, res_sum2, res_sum3} !== {1'b1, eid, 5'(e1), 9'(e2), 10'(e3)}) begin
        n_err++;
        $display("FAIL wrap_res[%0d]: got v=%b id=%b s1=%0d s2=%0d s3=%0d expected v=1 id=%b s1=%0d s2=%0d s3=%0d",
                 i, res_valid, res_id, res_sum1, res_sum2, res_sum3, eid, e1, e2, e3);
      end
      tick();
      exp_done = (exp_done + 1) % 256;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    res_ready = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    exp_done = 0;
    rst_n = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    res_ready = 1'b0;
    set_req0(4'd0, 4'd0, 8'd0, 8'd0);
    set_req1(4'd0, 4'd0, 8'd0, 8'd0);
    test_reset();
    test_dual();
    test_single();
    test_max();
    test_stall();
    test_reset_hold();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/adder_tree_arbiter.md
ADDER_TREE_ARBITER -- requirements
Module: adder_tree_arbiter

Interface
REQ-001 Parameter PRIO_RESET, default 0: requester holding round-robin priority after reset (0 or 1).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req0_valid / req1_valid  input  1 each  requester operand set valid.
REQ-005 req0_ready / req1_ready  output  1 each  operand set accepted this cycle.
REQ-006 req0_a, req0_b / req1_a, req1_b  input  4 each  narrow operands.
REQ-007 req0_c, req0_d / req1_c, req1_d  input  8 each  wide operands.
REQ-008 res_valid  output  1  result held for consumer.
REQ-009 res_ready  input  1  consumer accepts result.
REQ-010 res_sum1  output  5  a+b of the served operand set.
REQ-011 res_sum2  output  9  c+d of the served operand set.
REQ-012 res_sum3  output  10  res_sum1+res_sum2.
REQ-013 res_id  output  1  requester index that owns the result.
REQ-014 done_cnt  output  8  count of completed result handshakes.

Function
REQ-015 FSM states IDLE, CALC, HOLD; exactly one active at a time.
REQ-016 IDLE: no valid -> stay; any valid -> grant one requester, assert its ready combinationally this cycle, capture its a/b/c/d and index, go CALC.
REQ-017 Grant: single valid -> that requester; both valid -> requester named by priority pointer.
REQ-018 Priority pointer toggles to the non-granted requester on every accept, including single-valid accepts.
REQ-019 reqN_ready = (state==IDLE) && grant==N; never high for both; never high outside IDLE.
REQ-020 CALC: captured operands drive the adder tree; register sum1/sum2/sum3 and id into result outputs; go HOLD; lasts exactly 1 cycle.
REQ-021 HOLD: res_valid=1, result outputs stable until res_valid && res_ready; on handshake -> IDLE and done_cnt+1.
REQ-022 Latency: accept at cycle N -> res_valid high at N+2; minimum issue interval 3 cycles (no accept in HOLD).
REQ-023 Arithmetic unsigned, zero-extended; sum3 max 15+15+255+255=540 fits 10 bits, no overflow possible.
REQ-024 done_cnt wraps 255 -> 0 without flag.
REQ-025 Requester valid dropped before accept: no effect, no grant; operands sampled only on the accept cycle.
REQ-026 res_ready high while res_valid low: ignored.
REQ-027 New valid arriving during CALC/HOLD waits; served in next IDLE per REQ-017.

Reset
REQ-028 rst_n low asynchronously forces IDLE, res_valid=0, res_sum1/2/3=0, res_id=0, done_cnt=0, pointer=PRIO_RESET, both ready=0.
REQ-029 Reset mid CALC/HOLD discards the in-flight result; no handshake counted.
REQ-030 After rst_n rises, first accept may occur on the first clock edge.

Structure
REQ-031 Package adder_tree_pkg holds the state typedef (IDLE=2'b00, CALC=2'b01, HOLD=2'b10) and width constants NARROW_W=4, WIDE_W=8, SUM1_W=5, SUM2_W=9, SUM3_W=10.
REQ-032 One sub-module instance: adder_tree_procedural, fed from the captured-operand registers; no additional adders in the arbiter.

Verification
REQ-033 req0 only a=3,b=10,c=47,d=45 -> req0_ready 1 cycle; 2 cycles later res_valid, sum1=13, sum2=92, sum3=105, id=0.
REQ-034 Both valid after reset (PRIO_RESET=0): req0 a=1,b=2,c=79,d=141; req1 a=7,b=14,c=47,d=175 -> first result id=0 sum3=223, second id=1 sum1=21 sum2=222 sum3=243.
REQ-035 res_ready held low 5 cycles with result a=6,b=11,c=143,d=237 -> sum1=17, sum2=380, sum3=397 stable, res_valid high, no ready to requesters until handshake.
REQ-036 Max operands 15,15,255,255 -> sum1=30, sum2=510, sum3=540.
REQ-037 rst_n low during HOLD -> res_valid and sums 0 immediately (before clock edge), done_cnt unchanged at 0.
REQ-038 256 completed handshakes -> done_cnt returns to 0; pointer alternates every accept under continuous dual valid.
